// File: rtl/clint_irq_if.sv
// Purpose : decode-side bundle between the core and clint_irq (trap inputs, CSR write port, redirect).
// Latency : wires only; timing is set by the modules on either end.
// Backpressure: none here; the clint stalls fetch through o_clint_stall.
// Ports   : master = core side (drives i_*, observes o_*); slave = clint side.
interface clint_irq_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  i_insn_valid;
  logic [DATA_WIDTH-1:0] i_pc;
  logic [DATA_WIDTH-1:0] i_insn;
  logic [DATA_WIDTH-1:0] i_csr_mstatus;
  logic [DATA_WIDTH-1:0] i_csr_mie;
  logic [DATA_WIDTH-1:0] i_csr_mepc;
  logic [DATA_WIDTH-1:0] i_csr_mtvec;

  logic                  o_clint_mode;
  logic                  o_clint_csr_wr_en;
  logic [DATA_WIDTH-1:0] o_clint_csr_wr_addr;
  logic [DATA_WIDTH-1:0] o_clint_csr_wr_data;
  logic                  o_clint_stall;
  logic                  o_clint_assert;
  logic [DATA_WIDTH-1:0] o_pc_clint;

  modport master (
    output i_insn_valid, i_pc, i_insn, i_csr_mstatus, i_csr_mie, i_csr_mepc, i_csr_mtvec,
    input  o_clint_mode, o_clint_csr_wr_en, o_clint_csr_wr_addr, o_clint_csr_wr_data,
           o_clint_stall, o_clint_assert, o_pc_clint
  );

  modport slave (
    input  i_insn_valid, i_pc, i_insn, i_csr_mstatus, i_csr_mie, i_csr_mepc, i_csr_mtvec,
    output o_clint_mode, o_clint_csr_wr_en, o_clint_csr_wr_addr, o_clint_csr_wr_data,
           o_clint_stall, o_clint_assert, o_pc_clint
  );
endinterface

// File: rtl/clint_irq.sv
// Purpose : core-local trap controller (ecall/ebreak/mret, msip, mtime timer, synchronised external lines).
// Latency : trap CSR writes 2/3/4 cycles after detection (redirect with the last); mret write+redirect after 2.
// Backpressure: holds o_clint_stall while a sequence is in flight; decode is never consumed in that time.
// Ports   : clk, rst_n; bus (clint_irq_if.slave) decode/CSR/redirect signals;
//           i_ext_irq, i_msip interrupt sources; i_mtimecmp_wr_* timer compare writes; o_mtime current time.
module clint_irq #(
  parameter int DATA_WIDTH  = 32,
  parameter int MTIME_WIDTH = 64,
  parameter int NUM_EXT_IRQ = 4,
  parameter int MTIME_DIV   = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  clint_irq_if.slave             bus,
  input  logic [NUM_EXT_IRQ-1:0] i_ext_irq,
  input  logic                   i_msip,
  input  logic                   i_mtimecmp_wr_en,
  input  logic                   i_mtimecmp_wr_hi,
  input  logic [DATA_WIDTH-1:0]  i_mtimecmp_wr_data,
  output logic [MTIME_WIDTH-1:0] o_mtime
);

  localparam logic [31:0] INSN_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INSN_MRET   = 32'h3020_0073;

  localparam logic [DATA_WIDTH-1:0] CSR_MSTATUS = DATA_WIDTH'(12'h300);
  localparam logic [DATA_WIDTH-1:0] CSR_MEPC    = DATA_WIDTH'(12'h341);
  localparam logic [DATA_WIDTH-1:0] CSR_MCAUSE  = DATA_WIDTH'(12'h342);

  localparam int                PS_W   = (MTIME_DIV > 1) ? $clog2(MTIME_DIV) : 1;
  localparam logic [PS_W-1:0]   PS_MAX = PS_W'(MTIME_DIV - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MSTATUS = 3'd1,
    MEPC    = 3'd2,
    MCAUSE  = 3'd3,
    MRET    = 3'd4
  } state_t;

  state_t state_q, state_d;

  // ---------------- external line synchronisers ----------------
  logic [NUM_EXT_IRQ-1:0] ext_meta_q, ext_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_meta_q <= '0;
      ext_sync_q <= '0;
    end else begin
      ext_meta_q <= i_ext_irq;
      ext_sync_q <= ext_meta_q;
    end
  end

  // ---------------- timer ----------------
  logic [PS_W-1:0]        presc_q;
  logic [MTIME_WIDTH-1:0] mtime_q, mtimecmp_q;
  logic                   tick, mtip;

  assign tick = (presc_q == PS_MAX);
  assign mtip = (mtime_q >= mtimecmp_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
    end else begin
      presc_q <= tick ? '0 : presc_q + PS_W'(1);
      if (tick) mtime_q <= mtime_q + MTIME_WIDTH'(1);
      if (i_mtimecmp_wr_en) begin
        if (i_mtimecmp_wr_hi) mtimecmp_q[MTIME_WIDTH-1:DATA_WIDTH] <= i_mtimecmp_wr_data;
        else                  mtimecmp_q[DATA_WIDTH-1:0]           <= i_mtimecmp_wr_data;
      end
    end
  end

  assign o_mtime = mtime_q;

  // ---------------- pending / priority ----------------
  logic       ext_hit;
  logic [4:0] ext_code;

  // Walk downwards so the lowest enabled index is the one left standing.
  always_comb begin
    ext_hit  = 1'b0;
    ext_code = 5'd0;
    for (int k = NUM_EXT_IRQ - 1; k >= 0; k--) begin
      if (ext_sync_q[k] && bus.i_csr_mie[16+k]) begin
        ext_hit  = 1'b1;
        ext_code = 5'(16 + k);
      end
    end
  end

  logic       msi, mti, irq_any;
  logic [4:0] irq_code;
  logic       is_ecall, is_ebreak, is_mret, idle_valid;
  logic       take_irq, take_exc, take_mret;

  assign msi      = i_msip & bus.i_csr_mie[3];
  assign mti      = mtip & bus.i_csr_mie[7];
  assign irq_any  = bus.i_csr_mstatus[3] & (ext_hit | msi | mti);
  assign irq_code = ext_hit ? ext_code : (msi ? 5'd3 : 5'd7);

  assign is_ecall  = (bus.i_insn[31:0] == INSN_ECALL);
  assign is_ebreak = (bus.i_insn[31:0] == INSN_EBREAK);
  assign is_mret   = (bus.i_insn[31:0] == INSN_MRET);

  assign idle_valid = (state_q == IDLE) & bus.i_insn_valid;
  // An enabled interrupt wins over whatever instruction sits in decode.
  assign take_irq   = idle_valid & irq_any;
  assign take_exc   = idle_valid & ~irq_any & (is_ecall | is_ebreak);
  assign take_mret  = idle_valid & ~irq_any & is_mret;

  assign bus.o_clint_stall = (state_q != IDLE) | take_irq | take_exc | take_mret;

  // ---------------- trap context latched at detection ----------------
  logic [DATA_WIDTH-1:0] epc_q;
  logic                  cause_irq_q;
  logic [4:0]            cause_code_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      epc_q        <= '0;
      cause_irq_q  <= 1'b0;
      cause_code_q <= 5'd0;
    end else if (take_irq) begin
      epc_q        <= bus.i_pc;
      cause_irq_q  <= 1'b1;
      cause_code_q <= irq_code;
    end else if (take_exc) begin
      epc_q        <= bus.i_pc;
      cause_irq_q  <= 1'b0;
      cause_code_q <= is_ecall ? 5'd11 : 5'd3;
    end
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (take_irq || take_exc) state_d = MSTATUS;
        else if (take_mret)       state_d = MRET;
      end
      MSTATUS: state_d = MEPC;
      MEPC:    state_d = MCAUSE;
      MCAUSE:  state_d = IDLE;
      MRET:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs (registered one cycle later) ----------------
  logic                  wr_en_d, asrt_d, mode_d;
  logic [DATA_WIDTH-1:0] addr_d, data_d, pc_d;

  always_comb begin
    wr_en_d = 1'b0;
    asrt_d  = 1'b0;
    addr_d  = '0;
    data_d  = '0;
    pc_d    = '0;
    case (state_q)
      MSTATUS: begin
        wr_en_d      = 1'b1;
        addr_d       = CSR_MSTATUS;
        data_d       = bus.i_csr_mstatus;
        data_d[7]    = bus.i_csr_mstatus[3];
        data_d[3]    = 1'b0;
        data_d[12:11] = 2'b11;
      end
      MEPC: begin
        wr_en_d = 1'b1;
        addr_d  = CSR_MEPC;
        data_d  = epc_q;
      end
      MCAUSE: begin
        wr_en_d = 1'b1;
        addr_d  = CSR_MCAUSE;
        data_d  = {cause_irq_q, {(DATA_WIDTH-6){1'b0}}, cause_code_q};
        asrt_d  = 1'b1;
        pc_d    = {bus.i_csr_mtvec[DATA_WIDTH-1:2], 2'b00};
        // Vectored mode only offsets interrupts; exceptions go to the base.
        if (bus.i_csr_mtvec[1:0] == 2'b01 && cause_irq_q)
          pc_d = pc_d + DATA_WIDTH'({cause_code_q, 2'b00});
      end
      MRET: begin
        wr_en_d   = 1'b1;
        addr_d    = CSR_MSTATUS;
        data_d    = bus.i_csr_mstatus;
        data_d[3] = bus.i_csr_mstatus[7];
        data_d[7] = 1'b1;
        asrt_d    = 1'b1;
        pc_d      = bus.i_csr_mepc;
      end
      default: ;
    endcase
    // Mode covers the cycle after the last sequencing state so the final write still owns the port.
    mode_d = (state_d != IDLE) | (state_q != IDLE);
  end

  logic                  wr_en_q, asrt_q, mode_q;
  logic [DATA_WIDTH-1:0] addr_q, data_q, pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q <= 1'b0;
      asrt_q  <= 1'b0;
      mode_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      pc_q    <= '0;
    end else begin
      wr_en_q <= wr_en_d;
      asrt_q  <= asrt_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      pc_q    <= pc_d;
    end
  end

  assign bus.o_clint_mode        = mode_q;
  assign bus.o_clint_csr_wr_en   = wr_en_q;
  assign bus.o_clint_csr_wr_addr = addr_q;
  assign bus.o_clint_csr_wr_data = data_q;
  assign bus.o_clint_assert      = asrt_q;
  assign bus.o_pc_clint          = pc_q;

  // Only a handful of mie bits are interrupt enables here; upper insn bits matter only when wider than 32.
  logic unused_bits;
  assign unused_bits = ^{bus.i_csr_mie, bus.i_insn};

endmodule
